// File: rtl/vec_strided_vap_load.sv
// vec_strided_vap_load
//   Strided gather of vl variable-precision elements (vap = 1..32 bits each)
//   from a word-wide single-port memory. The elements are packed contiguously
//   into a VLEN-bit destination image. Masked-off elements and tail bits keep
//   their prior contents.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start                 one-cycle request, accepted only in IDLE
//   base, stride          byte address of element 0, signed byte stride
//   vl, vap               element count, element width in bits
//   vm, mask              vm=1 unmasked, else mask[i] enables element i
//   vd_old                prior destination contents
//   busy, done, error     status; error is valid while done=1
//   vd_data               result image, held until the next start
//   mem_valid/mem_ready   request / acknowledge handshake
//   mem_addr, mem_rdata   word-aligned address, read data
module vec_strided_vap_load #(
  parameter int VLEN   = 256,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base,
  input  logic [31:0]            stride,
  input  logic [$clog2(VLEN):0]  vl,
  input  logic [5:0]             vap,
  input  logic                   vm,
  input  logic [VLEN-1:0]        mask,
  input  logic [VLEN-1:0]        vd_old,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [VLEN-1:0]        vd_data,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [31:0]            mem_rdata
);

  localparam int CNT_W  = $clog2(VLEN) + 1;
  localparam int PROD_W = CNT_W + 6;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_ELEM    = 3'd2;
  localparam logic [2:0] S_REQ0    = 3'd3;
  localparam logic [2:0] S_REQ1    = 3'd4;
  localparam logic [2:0] S_EXTRACT = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]        state_reg;
  logic [31:0]       stride_reg;
  logic [CNT_W-1:0]  vl_reg;
  logic [5:0]        vap_reg;
  logic              vm_reg;
  logic [VLEN-1:0]   mask_reg;
  logic [CNT_W-1:0]  idx_reg;
  logic [ADDR_W-1:0] ea_reg;
  logic [ADDR_W-1:0] wa_reg;
  logic [4:0]        p_reg;
  logic [31:0]       lo_reg;
  logic [31:0]       hi_reg;
  logic              buf_valid_reg;
  logic [ADDR_W-1:0] buf_tag_reg;
  logic [31:0]       buf_data_reg;
  logic              error_reg;
  logic [VLEN-1:0]   vd_data_reg;
  logic [ADDR_W-1:0] mem_addr_reg;

  logic [PROD_W-1:0] total_bits;
  logic              cfg_bad;
  logic [ADDR_W-1:0] ea_wa;
  logic [4:0]        ea_p;
  logic              ea_straddle;
  logic              p_straddle;
  logic              elem_active;
  logic              buf_hit;
  logic [CNT_W-1:0]  idx_inc;
  logic              idx_last;
  logic [ADDR_W-1:0] ea_step;
  logic [31:0]       elem_mask;
  logic [31:0]       elem;
  logic [PROD_W-1:0] bit_off;
  logic [VLEN-1:0]   field_mask;
  logic [VLEN-1:0]   field_data;

  always_comb begin
    total_bits  = PROD_W'(vl_reg) * PROD_W'(vap_reg);
    cfg_bad     = (vap_reg == 6'd0) || (vap_reg > 6'd32) ||
                  (total_bits > PROD_W'(VLEN));
    ea_wa       = {ea_reg[ADDR_W-1:2], 2'b00};
    ea_p        = {ea_reg[1:0], 3'b000};
    // An element straddles when its last bit lies beyond bit 31 of its word.
    ea_straddle = (7'(ea_p) + 7'(vap_reg)) > 7'd32;
    p_straddle  = (7'(p_reg) + 7'(vap_reg)) > 7'd32;
    elem_active = vm_reg || mask_reg[idx_reg[CNT_W-2:0]];
    buf_hit     = buf_valid_reg && (buf_tag_reg == ea_wa);
    idx_inc     = idx_reg + CNT_W'(1);
    idx_last    = (idx_inc == vl_reg);
    ea_step     = ea_reg + ADDR_W'($signed(stride_reg));
    // 33-bit intermediate so that vap=32 yields an all-ones mask.
    elem_mask   = 32'((33'd1 << vap_reg) - 33'd1);
    // Shifting the {hi,lo} pair covers both the straddle and the in-word
    // case: for an in-word element the hi bits fall outside elem_mask.
    elem        = 32'({hi_reg, lo_reg} >> p_reg) & elem_mask;
    bit_off     = PROD_W'(idx_reg) * PROD_W'(vap_reg);
    field_mask  = VLEN'(elem_mask) << bit_off;
    field_data  = VLEN'(elem) << bit_off;
  end

  assign busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done      = (state_reg == S_DONE);
  assign mem_valid = (state_reg == S_REQ0) || (state_reg == S_REQ1);
  assign mem_addr  = mem_addr_reg;
  assign error     = error_reg;
  assign vd_data   = vd_data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      stride_reg    <= '0;
      vl_reg        <= '0;
      vap_reg       <= '0;
      vm_reg        <= 1'b0;
      mask_reg      <= '0;
      idx_reg       <= '0;
      ea_reg        <= '0;
      wa_reg        <= '0;
      p_reg         <= '0;
      lo_reg        <= '0;
      hi_reg        <= '0;
      buf_valid_reg <= 1'b0;
      buf_tag_reg   <= '0;
      buf_data_reg  <= '0;
      error_reg     <= 1'b0;
      vd_data_reg   <= '0;
      mem_addr_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            stride_reg    <= stride;
            vl_reg        <= vl;
            vap_reg       <= vap;
            vm_reg        <= vm;
            mask_reg      <= mask;
            vd_data_reg   <= vd_old;
            idx_reg       <= '0;
            ea_reg        <= base;
            buf_valid_reg <= 1'b0;
            error_reg     <= 1'b0;
            state_reg     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cfg_bad) begin
            error_reg <= 1'b1;
            state_reg <= S_DONE;
          end else if (vl_reg == '0) begin
            state_reg <= S_DONE;
          end else begin
            state_reg <= S_ELEM;
          end
        end
        S_ELEM: begin
          if (!elem_active) begin
            idx_reg   <= idx_inc;
            ea_reg    <= ea_step;
            state_reg <= idx_last ? S_DONE : S_ELEM;
          end else begin
            wa_reg <= ea_wa;
            p_reg  <= ea_p;
            if (buf_hit) begin
              lo_reg <= buf_data_reg;
              // The buffered word is only the low half of a straddling element.
              if (ea_straddle) begin
                mem_addr_reg <= ea_wa + ADDR_W'(4);
                state_reg    <= S_REQ1;
              end else begin
                state_reg <= S_EXTRACT;
              end
            end else begin
              mem_addr_reg <= ea_wa;
              state_reg    <= S_REQ0;
            end
          end
        end
        S_REQ0: begin
          if (mem_ready) begin
            lo_reg        <= mem_rdata;
            buf_valid_reg <= 1'b1;
            buf_tag_reg   <= wa_reg;
            buf_data_reg  <= mem_rdata;
            if (p_straddle) begin
              mem_addr_reg <= wa_reg + ADDR_W'(4);
              state_reg    <= S_REQ1;
            end else begin
              state_reg <= S_EXTRACT;
            end
          end
        end
        S_REQ1: begin
          if (mem_ready) begin
            hi_reg        <= mem_rdata;
            buf_valid_reg <= 1'b1;
            buf_tag_reg   <= wa_reg + ADDR_W'(4);
            buf_data_reg  <= mem_rdata;
            state_reg     <= S_EXTRACT;
          end
        end
        S_EXTRACT: begin
          vd_data_reg <= (vd_data_reg & ~field_mask) | field_data;
          idx_reg     <= idx_inc;
          ea_reg      <= ea_step;
          state_reg   <= idx_last ? S_DONE : S_ELEM;
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
